// File: rtl/nf10_filter_defs.sv
// Shared definitions for the nf10_filter datapath: gate FSM encoding, verdict values, counter width.
package nf10_filter_defs;

  localparam int unsigned CNT_W = 32;

  localparam logic VERDICT_SEND = 1'b1;
  localparam logic VERDICT_DROP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } gate_state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head entry while not empty.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_DEPTH_BITS = 3,
  parameter int unsigned NEARLY_FULL    = (2 ** MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic                      w_wr;
  logic                      w_rd;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign w_wr = wr_en & ~full;
  assign w_rd = rd_en & ~empty;

  // Storage array; no reset needed, occupancy tracking guards validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout        = r_mem[r_rd_ptr];
  assign full        = (r_count == CW'(DEPTH));
  assign nearly_full = (r_count >= CW'(NEARLY_FULL));
  assign empty       = (r_count == '0);

endmodule

// File: rtl/packet_gate_verdict_fifo.sv
// Verdict FIFO written by the parser: depth-1 nearly_full threshold plus sticky overflow flag.
module gate_verdict_fifo
  import nf10_filter_defs::*;
#(
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  input  logic i_wr_en,
  input  logic i_rd_en,
  output logic o_dout,
  output logic o_empty,
  output logic o_nearly_full,
  output logic o_overflow_err
);

  logic w_full;
  logic r_overflow_err;

  fallthrough_small_fifo #(
    .WIDTH          (1),
    .MAX_DEPTH_BITS (DEPTH_BITS),
    .NEARLY_FULL    ((2 ** DEPTH_BITS) - 1)
  ) u_fifo (
    .clk         (i_clk),
    .reset       (i_rst),
    .din         (i_din),
    .wr_en       (i_wr_en),
    .rd_en       (i_rd_en),
    .dout        (o_dout),
    .full        (w_full),
    .nearly_full (o_nearly_full),
    .empty       (o_empty)
  );

  // A push that finds the FIFO full is dropped; remember it until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)                   r_overflow_err <= 1'b0;
    else if (i_wr_en && w_full)  r_overflow_err <= 1'b1;
  end

  assign o_overflow_err = r_overflow_err;

endmodule

// File: rtl/packet_gate.sv
// Buffers each ingress packet until the parser verdict arrives, then forwards or discards it.
module packet_gate
  import nf10_filter_defs::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned DATA_DEPTH_BITS      = 9,
  parameter int unsigned RESULT_DEPTH_BITS    = 4
) (
  input  logic                                axi_aclk,
  input  logic                                axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  input  logic                                result_din,
  input  logic                                result_wr_en,
  output logic                                result_nearly_full,
  output logic [CNT_W-1:0]                    pass_count,
  output logic [CNT_W-1:0]                    drop_count,
  output logic                                overflow_err
);

  localparam int unsigned S_STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned M_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned FIFO_W   = 1 + C_S_AXIS_TUSER_WIDTH + S_STRB_W + C_S_AXIS_DATA_WIDTH;
  localparam int unsigned STRB_LO  = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned USER_LO  = STRB_LO + M_STRB_W;
  localparam int unsigned LAST_B   = USER_LO + C_M_AXIS_TUSER_WIDTH;

  gate_state_t       r_state;
  gate_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_pass_count;
  logic [CNT_W-1:0]  r_drop_count;

  logic [FIFO_W-1:0] w_data_head;
  logic              w_data_empty;
  logic              w_data_nearly_full;
  logic              w_data_full_unused;
  logic              w_data_rd;
  logic              w_head_last;
  logic              w_verdict;
  logic              w_verdict_empty;
  logic              w_verdict_rd;
  logic              w_pass_inc;
  logic              w_drop_inc;

  // Packet word buffer: {tlast, tuser, tstrb, tdata}.
  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (DATA_DEPTH_BITS),
    .NEARLY_FULL    ((2 ** DATA_DEPTH_BITS) - 1)
  ) u_data_fifo (
    .clk         (axi_aclk),
    .reset       (axi_areset),
    .din         ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
    .wr_en       (s_axis_tvalid & s_axis_tready),
    .rd_en       (w_data_rd),
    .dout        (w_data_head),
    .full        (w_data_full_unused),
    .nearly_full (w_data_nearly_full),
    .empty       (w_data_empty)
  );

  gate_verdict_fifo #(
    .DEPTH_BITS (RESULT_DEPTH_BITS)
  ) u_verdict_fifo (
    .i_clk          (axi_aclk),
    .i_rst          (axi_areset),
    .i_din          (result_din),
    .i_wr_en        (result_wr_en),
    .i_rd_en        (w_verdict_rd),
    .o_dout         (w_verdict),
    .o_empty        (w_verdict_empty),
    .o_nearly_full  (result_nearly_full),
    .o_overflow_err (overflow_err)
  );

  // Held low while reset is applied so nothing is captured into a FIFO being cleared.
  assign s_axis_tready = ~w_data_nearly_full & ~axi_areset;

  assign w_head_last  = w_data_head[LAST_B];
  assign m_axis_tdata = w_data_head[C_M_AXIS_DATA_WIDTH-1:0];
  assign m_axis_tstrb = w_data_head[USER_LO-1:STRB_LO];
  assign m_axis_tuser = w_data_head[LAST_B-1:USER_LO];
  assign m_axis_tlast = w_head_last;

  // State and counter registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state      <= ST_IDLE;
      r_pass_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pass_inc) r_pass_count <= r_pass_count + CNT_W'(1);
      if (w_drop_inc) r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  // Next state, FIFO pops and stream valid.
  always_comb begin
    w_state_nxt   = r_state;
    w_verdict_rd  = 1'b0;
    w_data_rd     = 1'b0;
    w_pass_inc    = 1'b0;
    w_drop_inc    = 1'b0;
    m_axis_tvalid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_verdict_empty && !w_data_empty) begin
          w_verdict_rd = 1'b1;
          w_state_nxt  = (w_verdict == VERDICT_SEND) ? ST_FORWARD : ST_DROP;
        end
      end
      ST_FORWARD: begin
        m_axis_tvalid = ~w_data_empty;
        w_data_rd     = ~w_data_empty & m_axis_tready;
        if (w_data_rd && w_head_last) begin
          w_pass_inc  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        w_data_rd = ~w_data_empty;
        if (w_data_rd && w_head_last) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign pass_count = r_pass_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_packet_gate.sv
// Scoreboard bench for packet_gate: stimulus queues expected words, a negedge monitor checks them.
module tb_packet_gate;

  localparam int unsigned DW = 256;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned UW = 128;

  typedef logic [DW+SW:0] exp_t;   // {tlast, tstrb, tdata}

  logic          clk;
  logic          axi_areset;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          result_din;
  logic          result_wr_en;
  logic          result_nearly_full;
  logic [31:0]   pass_count;
  logic [31:0]   drop_count;
  logic          overflow_err;

  packet_gate dut (
    .axi_aclk           (clk),
    .axi_areset         (axi_areset),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tstrb       (s_axis_tstrb),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tstrb       (m_axis_tstrb),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .result_din         (result_din),
    .result_wr_en       (result_wr_en),
    .result_nearly_full (result_nearly_full),
    .pass_count         (pass_count),
    .drop_count         (drop_count),
    .overflow_err       (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t          exp_q[$];
  exp_t          exp_word;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_valid_seen = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_pkt(input int base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), {SW{1'b1}}, DW'(base + i)});
  endtask

  task automatic send_pkt(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = DW'(base + i);
      s_axis_tstrb  = '1;
      s_axis_tuser  = UW'(i);
      s_axis_tlast  = (i == n - 1);
      s_axis_tvalid = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic push_verdict(input logic v);
    result_din   = v;
    result_wr_en = 1'b1;
    tick();
    result_wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget, input logic toggle);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      if (toggle) m_axis_tready = ~m_axis_tready;
      tick();
      k++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s: %0d expected words never appeared", name, exp_q.size());
    exp_q.delete();
    m_axis_tready = 1'b1;
  endtask

  // Output monitor: compares every accepted word against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (m_axis_tvalid === 1'b1) n_valid_seen++;
    if (prev_stall) begin
      n_checks++;
      if (m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data) n_pass++;
      else $display("FAIL hold_stable: valid=%b data=0x%0h held 0x%0h", m_axis_tvalid, m_axis_tdata, prev_data);
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word: got data=0x%0h last=%b with nothing expected", m_axis_tdata, m_axis_tlast);
      end else begin
        exp_word = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tstrb, m_axis_tdata} === exp_word) n_pass++;
        else $display("FAIL out_word: got 0x%0h expected 0x%0h", {m_axis_tlast, m_axis_tstrb, m_axis_tdata}, exp_word);
      end
    end
    prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0) && (axi_areset === 1'b0);
    prev_data  = m_axis_tdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    int k;
    axi_areset    = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    result_din    = 1'b0;
    result_wr_en  = 1'b0;

    // Reset state
    tick();
    check("tready_in_reset", 64'(s_axis_tready), 64'd0);
    tick();
    axi_areset = 1'b0;
    #1;
    check("tready_after_reset", 64'(s_axis_tready), 64'd1);
    check("tvalid_reset", 64'(m_axis_tvalid), 64'd0);
    check("pass_reset", 64'(pass_count), 64'd0);
    check("drop_reset", 64'(drop_count), 64'd0);
    check("ovf_reset", 64'(overflow_err), 64'd0);
    check("rnf_reset", 64'(result_nearly_full), 64'd0);

    // 4-word packet forwarded
    expect_pkt(32'h01, 4);
    send_pkt(32'h01, 4);
    push_verdict(1'b1);
    wait_drain("fwd_pkt", 30, 1'b0);
    repeat (2) tick();
    check("pass_after_fwd", 64'(pass_count), 64'd1);
    check("drop_after_fwd", 64'(drop_count), 64'd0);

    // Same packet dropped
    v0 = n_valid_seen;
    send_pkt(32'h01, 4);
    push_verdict(1'b0);
    repeat (12) tick();
    check("drop_no_valid", 64'(n_valid_seen - v0), 64'd0);
    check("drop_after_drop", 64'(drop_count), 64'd1);
    check("pass_after_drop", 64'(pass_count), 64'd1);

    // Three packets, late verdicts 1,0,1; third packet is single-word
    expect_pkt(32'h21, 3);
    expect_pkt(32'h41, 1);
    send_pkt(32'h21, 3);
    send_pkt(32'h31, 2);
    send_pkt(32'h41, 1);
    repeat (10) tick();
    push_verdict(1'b1);
    push_verdict(1'b0);
    push_verdict(1'b1);
    wait_drain("three_pkts", 60, 1'b0);
    repeat (4) tick();
    check("pass_three", 64'(pass_count), 64'd3);
    check("drop_three", 64'(drop_count), 64'd2);

    // Backpressure: tready toggles every cycle
    expect_pkt(32'h51, 6);
    send_pkt(32'h51, 6);
    push_verdict(1'b1);
    wait_drain("toggle_ready", 60, 1'b1);
    repeat (3) tick();
    check("pass_toggle", 64'(pass_count), 64'd4);

    // Reset while word 2 of a forwarded packet is presented
    m_axis_tready = 1'b0;
    expect_pkt(32'h61, 1);
    exp_q[0] = {1'b0, {SW{1'b1}}, DW'(32'h61)};
    send_pkt(32'h61, 4);
    push_verdict(1'b1);
    k = 0;
    while (m_axis_tvalid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("fwd_start_mid", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    axi_areset    = 1'b1;
    tick();
    axi_areset    = 1'b0;
    check("tvalid_mid_reset", 64'(m_axis_tvalid), 64'd0);
    check("pass_mid_reset", 64'(pass_count), 64'd0);
    check("drop_mid_reset", 64'(drop_count), 64'd0);
    check("word1_consumed", 64'(exp_q.size()), 64'd0);
    v0 = n_valid_seen;
    m_axis_tready = 1'b1;
    repeat (6) tick();
    check("no_tail", 64'(n_valid_seen - v0), 64'd0);
    expect_pkt(32'h71, 4);
    send_pkt(32'h71, 4);
    push_verdict(1'b1);
    wait_drain("after_reset_pkt", 30, 1'b0);
    repeat (2) tick();
    check("pass_after_reset", 64'(pass_count), 64'd1);

    // Verdict FIFO fill and overflow with no data to consume verdicts
    for (int i = 1; i <= 17; i++) begin
      push_verdict(1'b0);
      if (i == 14) check("rnf_at_14", 64'(result_nearly_full), 64'd0);
      if (i == 15) check("rnf_at_15", 64'(result_nearly_full), 64'd1);
      if (i == 16) check("ovf_at_16", 64'(overflow_err), 64'd0);
    end
    check("ovf_at_17", 64'(overflow_err), 64'd1);
    repeat (3) tick();
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    check("drop_no_data", 64'(drop_count), 64'd0);
    axi_areset = 1'b1;
    tick();
    axi_areset = 1'b0;
    check("ovf_cleared", 64'(overflow_err), 64'd0);
    check("rnf_cleared", 64'(result_nearly_full), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_gate.md
Name: packet_gate

Overview:
- Downstream companion of the header parser in the nf10_filter datapath. It receives a parallel copy of the ingress AXI-Stream and the parser's 1-bit verdict per packet (1 = send, 0 = drop).
- It buffers each packet until its verdict arrives, then forwards the whole packet to m_axis or discards it.
- It owns the verdict FIFO that the parser writes through result_din / result_wr_en / result_nearly_full, and keeps pass/drop counters for the register block.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master stream data width.
- C_S_AXIS_DATA_WIDTH, 256, slave stream data width; must equal master.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal master.
- DATA_DEPTH_BITS, 9, log2 of packet-buffer depth in words.
- RESULT_DEPTH_BITS, 4, log2 of verdict-FIFO depth.

Ports:
- axi_aclk  in  1  single clock; all logic on rising edge.
- axi_areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet word.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband (length/ports).
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  equals ~data_nearly_full.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tdata/tstrb/tuser/tlast  out  widths as slave  buffered word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream accept.
- result_din  in  1  parser verdict.
- result_wr_en  in  1  verdict push.
- result_nearly_full  out  1  asserted when verdict occupancy >= depth-1.
- pass_count  out  32  packets forwarded; wraps.
- drop_count  out  32  packets discarded; wraps.
- overflow_err  out  1  sticky; set when a verdict is pushed while the verdict FIFO is full.

Behaviour:
- Reset (axi_areset=1 at a clock edge):
  - both FIFOs empty; state IDLE; counters 0; overflow_err 0.
  - m_axis_tvalid 0; s_axis_tready 0 during reset, 1 the cycle after.
  - Reset mid-packet flushes the packet partially stored or partially sent; no partial tail is emitted afterwards.
- Data FIFO:
  - stores {tlast,tuser,tstrb,tdata}.
  - write = s_axis_tvalid & s_axis_tready.
  - nearly_full asserts at occupancy >= 2^DATA_DEPTH_BITS-1.
  - fall-through head.
- Verdict FIFO:
  - push = result_wr_en; a push when full is ignored and sets overflow_err.
  - simultaneous push+pop: occupancy unchanged; a push into an empty FIFO may be popped no earlier than the next cycle.
- FSM states IDLE, FORWARD, DROP:
  - IDLE: when verdict FIFO and data FIFO are both non-empty, pop the verdict. Verdict 1 -> FORWARD; verdict 0 -> DROP. Otherwise stay.
  - FORWARD:
    - m_axis_tvalid = ~data_empty; m_axis fields = data head.
    - pop on tvalid & tready.
    - popping the tlast word -> IDLE, pass_count+1.
    - the head stays stable while tvalid & ~tready.
  - DROP:
    - m_axis_tvalid = 0.
    - pop one word per cycle when non-empty.
    - popping the tlast word -> IDLE, drop_count+1.
- Latency:
  - verdict visible in IDLE -> first m_axis_tvalid on the next cycle.
  - one idle bubble between consecutive packets (tlast cycle -> IDLE -> next state).
- Single-word packet (tlast on word 0): handled identically; counter increments on that pop.
- Verdicts are consumed strictly in packet order; one verdict per packet.
- Counters wrap 0xFFFFFFFF -> 0.

Decomposition:
- Shared package/header nf10_filter_defs:
  - FSM state encodings (2-bit).
  - VERDICT_SEND=1'b1, VERDICT_DROP=1'b0.
  - counter width 32.
- Both buffers instantiate the existing fallthrough_small_fifo.
- One natural sub-module: gate_verdict_fifo. It wraps the verdict fallthrough_small_fifo and adds overflow_err and the depth-1 nearly_full threshold.

Test Plan:
- 4-word packet (words 0x01..0x04, tlast on 0x04) with verdict 1, m_axis_tready=1 -> 4 words out in order, tlast on word 4, pass_count=1, drop_count=0.
- Same packet with verdict 0 -> m_axis_tvalid never rises; data FIFO empty 4 cycles after DROP entry; drop_count=1.
- Three packets, verdicts 1,0,1; first verdict pushed 10 cycles after the packets are fully buffered -> packets 1 and 3 emitted, packet 2 absent; pass=2, drop=1.
- Forwarding with m_axis_tready toggling 1010… -> no word lost or duplicated; tdata stable while tvalid & ~tready.
- 17 verdict pushes with RESULT_DEPTH_BITS=4 and no pops -> result_nearly_full at 15 entries; 17th push ignored; overflow_err=1 until reset.
- axi_areset pulsed during word 2 of a forwarded 4-word packet -> m_axis_tvalid=0 the next cycle, counters 0; a following packet with verdict 1 is forwarded intact.
